comb_logic_sched: RTL and testbench

Sequenced, shared front end for the four-function two-operand ALU (add, multiply, compare, mux). Two requesters compete for the single ALU through valid/ready handshakes. A round-robin arbiter grants one request at a time and holds the operands in registers. A small FSM times each operation, with multiply taking several cycles. A registered response channel with backpressure returns the result, tagged with the requester ID.

---
 rtl/comb_logic_pkg.sv | 20 ++
 rtl/comb_logic_alu.sv | 48 ++++
 rtl/comb_logic_sched.sv | 167 ++++++++++++++++
 tb/tb_comb_logic_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comb_logic_pkg.sv
// -----------------------------------------------------------------------------
// comb_logic_pkg
// Shared definitions for the comb_logic_sched front end and its ALU:
//   - 2-bit opcode encodings (OP_ADD, OP_MUL, OP_COMP, OP_MUX)
//   - FSM state encoding (S_IDLE, S_EXEC, S_RESP)
// -----------------------------------------------------------------------------
package comb_logic_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_COMP = 2'b10;
  localparam logic [1:0] OP_MUX  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/comb_logic_alu.sv
// -----------------------------------------------------------------------------
// comb_logic_alu
// Purely combinational four-function, two-operand ALU.
// Ports:
//   x, y    in   DWIDTH    operands (unsigned)
//   inst    in   2         opcode: add, mul, comp, mux
//   sel     in   1         mux select (x when 1, y when 0)
//   result  out  2*DWIDTH  zero-extended result
//   flag    out  1         carry (add), x>=y (comp), sel (mux), 0 (mul)
// -----------------------------------------------------------------------------
module comb_logic_alu
  import comb_logic_pkg::*;
#(
  parameter int DWIDTH = 4
) (
  input  logic [DWIDTH-1:0]   x,
  input  logic [DWIDTH-1:0]   y,
  input  logic [1:0]          inst,
  input  logic                sel,
  output logic [2*DWIDTH-1:0] result,
  output logic                flag
);

  localparam int RW = 2 * DWIDTH;

  logic [DWIDTH:0] sum;

  // NOTE: every output of a combinational block gets a default before the
  // case; any path that leaves one unassigned would infer a latch.
  always_comb begin
    result = '0;
    flag   = 1'b0;
    sum    = {1'b0, x} + {1'b0, y};
    case (inst)
      OP_ADD: begin
        result = RW'(sum);
        flag   = sum[DWIDTH];
      end
      OP_MUL:  result = RW'(x) * RW'(y);
      OP_COMP: flag = (x >= y);
      OP_MUX: begin
        result = RW'(sel ? x : y);
        flag   = sel;
      end
    endcase
  end

endmodule

// File: rtl/comb_logic_sched.sv
// -----------------------------------------------------------------------------
// comb_logic_sched
// Two-requester, round-robin sequenced front end for a shared ALU.
// Requests are accepted in IDLE, timed in EXEC (multiply takes MUL_CYCLES),
// and returned through a registered response channel with backpressure.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid[1:0]         per-requester request valid
//   req_ready[1:0]         per-requester accept (one-hot or zero, comb.)
//   req_x, req_y           packed operands, requester i at [i*DWIDTH +: DWIDTH]
//   req_inst[3:0]          packed 2-bit opcodes
//   req_sel[1:0]           per-requester mux select
//   rsp_valid / rsp_ready  response handshake
//   rsp_id, rsp_inst       originating requester and opcode
//   rsp_result, rsp_flag   ALU result (zero-extended) and flag
//   busy                   high whenever the FSM is not in IDLE
// Optional feature: define COMB_LOGIC_SCHED_STATS_EN to add the saturating
// 16-bit handshake counters grant_cnt0 / grant_cnt1.
// -----------------------------------------------------------------------------
module comb_logic_sched
  import comb_logic_pkg::*;
#(
  parameter int DWIDTH     = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DWIDTH-1:0] req_x,
  input  logic [2*DWIDTH-1:0] req_y,
  input  logic [3:0]          req_inst,
  input  logic [1:0]          req_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [1:0]          rsp_inst,
  output logic [2*DWIDTH-1:0] rsp_result,
  output logic                rsp_flag,
`ifdef COMB_LOGIC_SCHED_STATS_EN
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1,
`endif
  output logic                busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t              state, state_next;
  logic                rr;
  logic [CNT_W-1:0]    cnt;

  logic                gnt_valid, gnt_id, handshake;
  logic [DWIDTH-1:0]   gnt_x, gnt_y;
  logic [1:0]          gnt_inst;
  logic                gnt_sel;

  logic [DWIDTH-1:0]   x_r, y_r;
  logic [1:0]          inst_r;
  logic                sel_r, id_r;

  logic [2*DWIDTH-1:0] alu_result;
  logic                alu_flag;

  // Round-robin: requester rr has priority, the other one takes the slot
  // only when rr is not asking.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = rr;
    if (req_valid[rr]) begin
      gnt_valid = 1'b1;
    end else if (req_valid[~rr]) begin
      gnt_valid = 1'b1;
      gnt_id    = ~rr;
    end
  end

  assign gnt_x     = gnt_id ? req_x[DWIDTH +: DWIDTH] : req_x[0 +: DWIDTH];
  assign gnt_y     = gnt_id ? req_y[DWIDTH +: DWIDTH] : req_y[0 +: DWIDTH];
  assign gnt_inst  = gnt_id ? req_inst[3:2] : req_inst[1:0];
  assign gnt_sel   = gnt_id ? req_sel[1] : req_sel[0];
  assign handshake = (state == S_IDLE) && gnt_valid;
  assign req_ready = handshake ? (2'b01 << gnt_id) : 2'b00;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (handshake)        state_next = S_EXEC;
      S_EXEC: if (cnt == '0)        state_next = S_RESP;
      S_RESP: if (rsp_ready)        state_next = S_IDLE;
      default:                      state_next = S_IDLE;
    endcase
  end

  comb_logic_alu #(.DWIDTH(DWIDTH)) u_alu (
    .x      (x_r),
    .y      (y_r),
    .inst   (inst_r),
    .sel    (sel_r),
    .result (alu_result),
    .flag   (alu_flag)
  );

  // Operand capture, cycle counter and response registers. rsp_valid and
  // busy are registered copies of the next state so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr         <= 1'b0;
      cnt        <= '0;
      x_r        <= '0;
      y_r        <= '0;
      inst_r     <= '0;
      sel_r      <= 1'b0;
      id_r       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_inst   <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (handshake) begin
          x_r    <= gnt_x;
          y_r    <= gnt_y;
          inst_r <= gnt_inst;
          sel_r  <= gnt_sel;
          id_r   <= gnt_id;
          cnt    <= (gnt_inst == OP_MUL) ? MUL_LAST : '0;
          rr     <= ~gnt_id;
        end
        S_EXEC: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_id     <= id_r;
          rsp_inst   <= inst_r;
          rsp_result <= alu_result;
          rsp_flag   <= alu_flag;
        end
        default: ;
      endcase
      rsp_valid <= (state_next == S_RESP);
      busy      <= (state_next != S_IDLE);
    end
  end

`ifdef COMB_LOGIC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (handshake) begin
      if (!gnt_id && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt_id && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comb_logic_sched.sv
// -----------------------------------------------------------------------------
// tb_comb_logic_sched
// Self-checking bench for comb_logic_sched. Expected results come from an
// integer-arithmetic ALU model and a simple "last winner loses priority"
// fairness model. Define COMB_LOGIC_SCHED_STATS_EN to also cover the
// grant counters.
// -----------------------------------------------------------------------------
module tb_comb_logic_sched;
  import comb_logic_pkg::*;

  localparam int DW = 4;
  localparam int MC = 2;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_x, req_y;
  logic [3:0]      req_inst;
  logic [1:0]      req_sel;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [1:0]      rsp_inst;
  logic [2*DW-1:0] rsp_result;
  logic            rsp_flag;
  logic            busy;
`ifdef COMB_LOGIC_SCHED_STATS_EN
  logic [15:0]     grant_cnt0, grant_cnt1;
`endif

  comb_logic_sched #(.DWIDTH(DW), .MUL_CYCLES(MC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_inst   (req_inst),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_inst   (rsp_inst),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
`ifdef COMB_LOGIC_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_rr  = 0;

  // {flag, result} computed with plain integer arithmetic
  function automatic logic [2*DW:0] model(input int a, input int b,
                                          input int op, input int s);
    int r;
    bit f;
    r = 0;
    f = 1'b0;
    case (op)
      0: begin r = a + b; f = (r >= (1 << DW)); end
      1: r = a * b;
      2: f = (a >= b);
      default: begin r = (s != 0) ? a : b; f = (s != 0); end
    endcase
    return {f, (2*DW)'(r)};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b0;
    req_x = '0; req_y = '0; req_inst = '0; req_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rr = 0;
  endtask

  // Single-requester operation: handshake, latency, response fields, retire.
  task automatic run_op(input int id, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [1:0] inst, input logic sel, input string name);
    logic [2*DW:0] exp;
    int lat, cyc;
    exp = model(int'(x), int'(y), int'(inst), int'(sel));
    lat = (inst == OP_MUL) ? MC : 1;
    @(negedge clk);
    req_x = 8'($urandom); req_y = 8'($urandom);
    req_inst = 4'($urandom); req_sel = 2'($urandom);
    req_x[id*DW +: DW] = x;
    req_y[id*DW +: DW] = y;
    req_inst[id*2 +: 2] = inst;
    req_sel[id] = sel;
    req_valid = 2'b01 << id;
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== (2'b01 << id))
      $display("FAIL %s ready: got %b expected %b", name, req_ready, 2'b01 << id);
    else n_pass++;
    @(posedge clk); #1;
    exp_rr = 1 - id;
    req_valid = 2'b00;
    req_x = 8'($urandom); req_y = 8'($urandom);
    req_inst = 4'($urandom); req_sel = 2'($urandom);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (rsp_valid !== 1'b1 && cyc < 20);
    n_total++;
    if (cyc != lat) $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
    else n_pass++;
    n_total++;
    if ({busy, rsp_id, rsp_inst, rsp_flag, rsp_result} !== {1'b1, 1'(id), inst, exp})
      $display("FAIL %s rsp: got busy=%b id=%b inst=%b flag=%b res=%h expected busy=1 id=%0d inst=%b flag=%b res=%h",
               name, busy, rsp_id, rsp_inst, rsp_flag, rsp_result, id, inst, exp[2*DW], exp[2*DW-1:0]);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL %s retire: got valid=%b busy=%b expected 0 0", name, rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b0;
    req_x = '0; req_y = '0; req_inst = '0; req_sel = '0;
    @(posedge clk); #1;
    n_total++;
    if ({req_ready, rsp_valid, busy, rsp_id, rsp_inst, rsp_flag, rsp_result} !== '0)
      $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b id=%b inst=%b flag=%b res=%h expected all 0",
               req_ready, rsp_valid, busy, rsp_id, rsp_inst, rsp_flag, rsp_result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rr = 0;
    @(negedge clk); #1;
    n_total++;
    if ({req_ready, rsp_valid, busy} !== 4'b0000)
      $display("FAIL reset_idle: got rdy=%b v=%b busy=%b expected 0", req_ready, rsp_valid, busy);
    else n_pass++;
    req_valid = 2'b11; #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL reset_prio: got %b expected 01", req_ready);
    else n_pass++;
    req_valid = 2'b10; #1;
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL reset_only1: got %b expected 10", req_ready);
    else n_pass++;
    req_valid = 2'b00;
  endtask

  task automatic test_add();
    run_op(0, 4'hF, 4'h1, OP_ADD, 1'b0, "add_carry");
    run_op(1, 4'h3, 4'h4, OP_ADD, 1'b0, "add_nocarry");
  endtask

  task automatic test_mul();
    run_op(1, 4'hF, 4'hF, OP_MUL, 1'b0, "mul_max");
    run_op(0, 4'h0, 4'h9, OP_MUL, 1'b1, "mul_zero");
  endtask

  task automatic test_comp_mux();
    run_op(0, 4'h3, 4'h3, OP_COMP, 1'b0, "comp_eq");
    run_op(1, 4'h2, 4'h3, OP_COMP, 1'b0, "comp_lt");
    run_op(0, 4'h5, 4'hA, OP_MUX, 1'b1, "mux_sel1");
    run_op(1, 4'h5, 4'hA, OP_MUX, 1'b0, "mux_sel0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op(int'($urandom_range(1, 0)), 4'($urandom), 4'($urandom),
             2'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_fairness();
    logic [2*DW:0] exp;
    int g, cyc;
    apply_reset();
    @(negedge clk);
    req_x = {4'h2, 4'h3}; req_y = {4'h5, 4'h4};
    req_inst = {OP_MUL, OP_ADD}; req_sel = 2'b00;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = exp_rr;
      #1;
      cyc = 0;
      while (req_ready === 2'b00 && cyc < 20) begin @(negedge clk); #1; cyc++; end
      n_total++;
      if (req_ready !== (2'b01 << g) || g != (k % 2))
        $display("FAIL fair_grant%0d: got %b expected %b", k, req_ready, 2'b01 << (k % 2));
      else n_pass++;
      exp_rr = 1 - g;
      exp = (g == 0) ? model(3, 4, 0, 0) : model(2, 5, 1, 0);
      @(posedge clk); #1;
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      n_total++;
      if ({rsp_id, rsp_flag, rsp_result} !== {1'(g), exp})
        $display("FAIL fair_rsp%0d: got id=%b flag=%b res=%h expected id=%0d flag=%b res=%h",
                 k, rsp_id, rsp_flag, rsp_result, g, exp[2*DW], exp[2*DW-1:0]);
      else n_pass++;
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
`ifdef COMB_LOGIC_SCHED_STATS_EN
    n_total++;
    if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2)
      $display("FAIL fair_stats: got %0d/%0d expected 2/2", grant_cnt0, grant_cnt1);
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    logic [2*DW:0] exp;
    int cyc;
    exp = model(9, 2, 2, 0);
    @(negedge clk);
    req_x = {4'h0, 4'h9}; req_y = {4'h0, 4'h2};
    req_inst = {OP_ADD, OP_COMP}; req_sel = 2'b00;
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(posedge clk); #1;
    exp_rr = 1;
    req_valid = 2'b11;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (rsp_valid !== 1'b1 && cyc < 20);
    n_total++;
    if (cyc != 1) $display("FAIL bp_latency: got %0d expected 1", cyc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({rsp_valid, busy, req_ready, rsp_id, rsp_inst, rsp_flag, rsp_result} !==
          {1'b1, 1'b1, 2'b00, 1'b0, OP_COMP, exp})
        $display("FAIL bp_hold%0d: got v=%b busy=%b rdy=%b id=%b inst=%b flag=%b res=%h expected v=1 busy=1 rdy=00 id=0 inst=10 flag=%b res=%h",
                 i, rsp_valid, busy, req_ready, rsp_id, rsp_inst, rsp_flag, rsp_result,
                 exp[2*DW], exp[2*DW-1:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 2'b01 << exp_rr})
      $display("FAIL bp_retire: got v=%b busy=%b rdy=%b expected v=0 busy=0 rdy=%b",
               rsp_valid, busy, req_ready, 2'b01 << exp_rr);
    else n_pass++;
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL bp_idle: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req_x = {4'h7, 4'h0}; req_y = {4'h3, 4'h0};
    req_inst = {OP_MUL, OP_ADD}; req_sel = 2'b00;
    req_valid = 2'b10; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready, rsp_valid, busy, rsp_id, rsp_inst, rsp_flag, rsp_result} !== '0)
      $display("FAIL rstmid_outputs: got rdy=%b v=%b busy=%b id=%b inst=%b flag=%b res=%h expected all 0",
               req_ready, rsp_valid, busy, rsp_id, rsp_inst, rsp_flag, rsp_result);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rr = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL rstmid_noresp: got %0d active cycles expected 0", seen);
    else n_pass++;
    @(negedge clk);
    req_valid = 2'b11; #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL rstmid_first_grant: got %b expected 01", req_ready);
    else n_pass++;
    req_valid = 2'b00;
    run_op(1, 4'h7, 4'h3, OP_MUL, 1'b0, "rstmid_recover");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_comp_mux();
    test_random();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
